// File: rtl/kws_pkg.sv
// Shared constants and types for the keyword-spotting front end.
// Q1.7.24 fixed point, frame geometry and the CMVN sender state encoding.
package kws_pkg;

    localparam int unsigned FRAME_LEN = 20;
    localparam int unsigned FRAC_BITS = 24;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        FILL,
        SEND,
        DRAIN
    } cmvn_state_e;

endpackage

// File: rtl/cmvn_tx_if.sv
// Bus bundle for cmvn_tx: filterbank write port, coefficient port and output stream.
// slave is the CMVN block; master is whoever feeds and drains it.
interface cmvn_tx_if;

    logic [31:0] fbank_data;
    logic [4:0]  fbank_addr;
    logic        fbank_valid;
    logic        fbank_ready;

    logic        coef_we;
    logic        coef_sel;
    logic [4:0]  coef_addr;
    logic [31:0] coef_data;

    logic        tx_ready;
    logic [31:0] cmvn_output_data;
    logic [4:0]  cmvn_output_addr;
    logic        cmvn_output_valid;
    logic        frame_done;

    modport slave (
        input  fbank_data, fbank_addr, fbank_valid,
        output fbank_ready,
        input  coef_we, coef_sel, coef_addr, coef_data,
        input  tx_ready,
        output cmvn_output_data, cmvn_output_addr, cmvn_output_valid, frame_done
    );

    modport master (
        output fbank_data, fbank_addr, fbank_valid,
        input  fbank_ready,
        output coef_we, coef_sel, coef_addr, coef_data,
        output tx_ready,
        input  cmvn_output_data, cmvn_output_addr, cmvn_output_valid, frame_done
    );

endinterface

// File: rtl/q_mul_sat.sv
// Signed 33x32 fixed-point multiply, rescale by FRAC_BITS and saturate to Q1.7.24.
module q_mul_sat #(
    parameter int unsigned FRAC_BITS = kws_pkg::FRAC_BITS
) (
    input  logic signed [32:0] diff,
    input  logic signed [31:0] coef,
    output logic        [31:0] result
);
    import kws_pkg::*;

    logic signed [64:0]          prod;
    logic        [33-FRAC_BITS:0] hi;

    // The result fits only if every bit above the kept window matches its sign.
    always_comb begin
        prod = 65'(diff) * 65'(coef);
        hi   = prod[64:FRAC_BITS+31];
        if (hi == '0 || hi == '1) begin
            result = prod[FRAC_BITS+31:FRAC_BITS];
        end else if (prod[64]) begin
            result = SAT_MIN;
        end else begin
            result = SAT_MAX;
        end
    end

endmodule

// File: rtl/cmvn_tx.sv
// Cepstral mean/variance normalisation: buffers one filterbank frame, then streams
// (x - mean) * inv_std per element through a two-stage pipeline with backpressure.
module cmvn_tx #(
    parameter int unsigned FRAME_LEN = kws_pkg::FRAME_LEN,
    parameter int unsigned FRAC_BITS = kws_pkg::FRAC_BITS
) (
    input logic      clk,
    input logic      rst,
    cmvn_tx_if.slave bus
);
    import kws_pkg::*;

    localparam logic [4:0] LAST_IDX    = 5'(FRAME_LEN - 1);
    localparam logic [5:0] FRAME_LEN_W = 6'(FRAME_LEN);

    cmvn_state_e state_q, state_d;

    logic [31:0] fbuf     [FRAME_LEN];
    logic [31:0] mean_tab [FRAME_LEN];
    logic [31:0] istd_tab [FRAME_LEN];

    logic [FRAME_LEN-1:0] written;
    logic [5:0]           fill_cnt;
    logic [4:0]           issue_cnt;

    logic               s1_valid;
    logic signed [32:0] s1_diff;
    logic signed [31:0] s1_istd;
    logic [4:0]         s1_addr;

    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic [31:0] prod_sat;

    logic fb_addr_ok, coef_addr_ok;
    logic fill_wr, fill_new, fill_done;
    logic stall, xfer, last_xfer;
    logic issue_en, fbank_ready_c, frame_done_c;

    always_comb begin
        fb_addr_ok   = {1'b0, bus.fbank_addr} < FRAME_LEN_W;
        coef_addr_ok = {1'b0, bus.coef_addr} < FRAME_LEN_W;
        fill_wr      = (state_q == FILL) && bus.fbank_valid && fb_addr_ok;
        fill_new     = fill_wr && !written[bus.fbank_addr];
        fill_done    = fill_new && (fill_cnt == FRAME_LEN_W - 6'd1);
        stall        = out_valid && !bus.tx_ready;
        xfer         = out_valid && bus.tx_ready;
        last_xfer    = xfer && (out_addr == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:  if (fill_done) state_d = SEND;
            SEND:  if (issue_en && issue_cnt == LAST_IDX) state_d = DRAIN;
            DRAIN: if (last_xfer) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        fbank_ready_c = (state_q == FILL);
        issue_en      = (state_q == SEND) && !stall;
        frame_done_c  = last_xfer;
    end

    // Storage arrays carry no reset: a reset drops the frame but keeps the tables.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            fbuf[bus.fbank_addr] <= bus.fbank_data;
        end
        if (bus.coef_we && coef_addr_ok) begin
            if (bus.coef_sel) begin
                istd_tab[bus.coef_addr] <= bus.coef_data;
            end else begin
                mean_tab[bus.coef_addr] <= bus.coef_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            written   <= '0;
            fill_cnt  <= '0;
            issue_cnt <= '0;
            s1_valid  <= 1'b0;
            s1_diff   <= '0;
            s1_istd   <= '0;
            s1_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            if (fill_wr) begin
                written[bus.fbank_addr] <= 1'b1;
            end
            if (fill_new) begin
                fill_cnt <= fill_cnt + 6'd1;
            end
            if (last_xfer) begin
                written  <= '0;
                fill_cnt <= '0;
            end
            if (issue_en) begin
                issue_cnt <= (issue_cnt == LAST_IDX) ? '0 : issue_cnt + 5'd1;
            end
            // istd is captured at issue so later table writes only affect later elements.
            if (!stall) begin
                s1_valid <= issue_en;
                if (issue_en) begin
                    s1_diff <= 33'(signed'(fbuf[issue_cnt])) - 33'(signed'(mean_tab[issue_cnt]));
                    s1_istd <= istd_tab[issue_cnt];
                    s1_addr <= issue_cnt;
                end
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= prod_sat;
                    out_addr <= s1_addr;
                end
            end
        end
    end

    q_mul_sat #(.FRAC_BITS(FRAC_BITS)) u_mul (
        .diff   (s1_diff),
        .coef   (s1_istd),
        .result (prod_sat)
    );

    assign bus.fbank_ready       = fbank_ready_c;
    assign bus.frame_done        = frame_done_c;
    assign bus.cmvn_output_valid = out_valid;
    assign bus.cmvn_output_data  = out_data;
    assign bus.cmvn_output_addr  = out_addr;

endmodule
